// File: rtl/mimo_layer_skew_buffer.sv
// Input skew buffer for the K-best MIMO detector: delays each R row and Y element so it reaches its layer stage in step with the surviving paths.
// Optional build macro SKEW_ZERO_GATE_EN zeroes the data carried in invalid slots to cut toggle power.
module mimo_layer_skew_buffer #(
  parameter int WL        = 15,
  parameter int NLAYER    = 8,
  parameter int STAGE_LAT = 4,
  parameter int NR        = NLAYER * (NLAYER + 1) / 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   in_valid,
  input  logic [NR*WL-1:0]                       r_in,
  input  logic [NLAYER*WL-1:0]                   y_in,
  output logic [NR*WL-1:0]                       r_out,
  output logic [NLAYER*WL-1:0]                   y_out,
  output logic [NLAYER-1:0]                      lay_valid,
  output logic [$clog2(NLAYER*STAGE_LAT+2)-1:0]  inflight
);

  localparam int IW  = $clog2(NLAYER*STAGE_LAT+2);
  localparam int TOP = (NR - 1) * WL;

  function automatic int row_off(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += NLAYER - j;
    return s;
  endfunction

  if (NLAYER < 2) begin : g_bad_nlayer
    $error("mimo_layer_skew_buffer: NLAYER must be at least 2");
  end
  if (STAGE_LAT < 1) begin : g_bad_stage_lat
    $error("mimo_layer_skew_buffer: STAGE_LAT must be at least 1");
  end
  if (NR != NLAYER * (NLAYER + 1) / 2) begin : g_bad_nr
    $error("mimo_layer_skew_buffer: NR is derived from NLAYER and must not be overridden");
  end

  logic in_keep;
`ifdef SKEW_ZERO_GATE_EN
  assign in_keep = in_valid;
`else
  assign in_keep = 1'b1;
`endif

  // Top row feeds the path generator directly, so it bypasses the enable.
  assign r_out[TOP +: WL]              = {WL{in_keep}} & r_in[TOP +: WL];
  assign y_out[(NLAYER-1)*WL +: WL]    = {WL{in_keep}} & y_in[(NLAYER-1)*WL +: WL];
  assign lay_valid[NLAYER-1]           = in_valid;

  for (genvar k = 0; k < NLAYER - 1; k++) begin : g_lay
    localparam int D   = 1 + STAGE_LAT * (NLAYER - 2 - k);
    localparam int RW  = (NLAYER - k) * WL;
    localparam int W   = RW + WL + 1;
    localparam int OFF = row_off(k);

    logic [W-1:0]        chain_d;
    logic [D-1:0][W-1:0] chain_q;

    // Each slot is {row k words, y[k], valid}; only the row's own words are stored.
    assign chain_d = {{RW{in_keep}} & r_in[OFF*WL +: RW],
                      {WL{in_keep}} & y_in[k*WL +: WL],
                      in_valid & en};

    always_ff @(posedge clk) begin
      if (rst) begin
        chain_q <= '0;
      end else if (en) begin
        chain_q[0] <= chain_d;
        for (int i = 1; i < D; i++) chain_q[i] <= chain_q[i-1];
      end
    end

    assign r_out[OFF*WL +: RW] = chain_q[D-1][W-1 -: RW];
    assign y_out[k*WL +: WL]   = chain_q[D-1][WL:1];
    assign lay_valid[k]        = chain_q[D-1][0];
  end

  logic [IW-1:0] inflight_q, inflight_d;
  logic          acc, ret;

  assign acc = en & in_valid;
  assign ret = en & lay_valid[0];

  always_comb begin
    inflight_d = inflight_q;
    if (acc && !ret)      inflight_d = inflight_q + IW'(1);
    else if (!acc && ret) inflight_d = inflight_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;

endmodule

// File: tb/tb_mimo_layer_skew_buffer.sv
// Bench for mimo_layer_skew_buffer: directed scenarios plus random traffic against an age-indexed history model;
// a second small instance covers NLAYER=4, STAGE_LAT=2, WL=8.
module tb_mimo_layer_skew_buffer;
  localparam int WL = 15, NL = 8, SL = 4;
  localparam int NR = NL * (NL + 1) / 2;
  localparam int IW = $clog2(NL*SL+2);
  localparam int D0 = 1 + SL * (NL - 2);
  localparam int RB = NR * WL, YB = NL * WL;

  localparam int S_WL = 8, S_NL = 4, S_SL = 2, S_NR = 10;
  localparam int S_IW = $clog2(S_NL*S_SL+2);

  logic clk = 1'b0;
  logic rst, en, in_valid;
  logic [RB-1:0] r_in, r_out;
  logic [YB-1:0] y_in, y_out;
  logic [NL-1:0] lay_valid;
  logic [IW-1:0] inflight;

  logic s_rst, s_en, s_valid;
  logic [S_NR*S_WL-1:0] s_r_in, s_r_out;
  logic [S_NL*S_WL-1:0] s_y_in, s_y_out;
  logic [S_NL-1:0]      s_lay_valid;
  logic [S_IW-1:0]      s_inflight;

  always #5 clk = ~clk;

  mimo_layer_skew_buffer #(.WL(WL), .NLAYER(NL), .STAGE_LAT(SL)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .r_in(r_in), .y_in(y_in),
    .r_out(r_out), .y_out(y_out), .lay_valid(lay_valid), .inflight(inflight));

  mimo_layer_skew_buffer #(.WL(S_WL), .NLAYER(S_NL), .STAGE_LAT(S_SL)) s_dut (
    .clk(clk), .rst(s_rst), .en(s_en), .in_valid(s_valid), .r_in(s_r_in), .y_in(s_y_in),
    .r_out(s_r_out), .y_out(s_y_out), .lay_valid(s_lay_valid), .inflight(s_inflight));

  typedef struct packed {
    logic [RB-1:0] r;
    logic [YB-1:0] y;
    logic          v;
  } vec_t;

  // hist[a] is the vector accepted a+1 enabled steps ago; reset refills it with zeros.
  vec_t hist[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int dly(input int k);
    return (k == NL - 1) ? 0 : 1 + SL * (NL - 2 - k);
  endfunction

  function automatic int roff(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += NL - j;
    return s;
  endfunction

  function automatic logic [RB-1:0] rmask(input int k);
    logic [RB-1:0] m;
    m = '0;
    for (int b = roff(k) * WL; b < (roff(k) + NL - k) * WL; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D0; i++) hist.push_back('0);
  endtask

  task automatic model_step();
    vec_t e;
    if (rst) begin
      model_reset();
    end else if (en) begin
      e.r = r_in; e.y = y_in; e.v = in_valid;
`ifdef SKEW_ZERO_GATE_EN
      if (!in_valid) begin e.r = '0; e.y = '0; end
`endif
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endtask

  task automatic compare_model();
    logic [RB-1:0] m;
    logic [WL-1:0] et, eyt;
    vec_t e;
    int cnt;
    for (int k = 0; k < NL - 1; k++) begin
      e = hist[dly(k) - 1];
      m = rmask(k);
      chk($sformatf("row%0d", k), r_out & m, e.r & m);
      chk($sformatf("y%0d", k), y_out[k*WL +: WL], e.y[k*WL +: WL]);
      chk($sformatf("lv%0d", k), lay_valid[k], e.v);
    end
    et  = r_in[(NR-1)*WL +: WL];
    eyt = y_in[(NL-1)*WL +: WL];
`ifdef SKEW_ZERO_GATE_EN
    if (!in_valid) begin et = '0; eyt = '0; end
`endif
    chk("row_top", r_out[(NR-1)*WL +: WL], et);
    chk("y_top", y_out[(NL-1)*WL +: WL], eyt);
    chk("lv_top", lay_valid[NL-1], in_valid);
    cnt = 0;
    for (int i = 0; i < D0; i++) cnt += int'(hist[i].v);
    chk("inflight", inflight, cnt);
  endtask

  task automatic drive(input logic r, input logic e, input logic v);
    rst = r; en = e; in_valid = v;
    for (int i = 0; i < RB; i++) r_in[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < YB; i++) y_in[i] = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic tick(input bit cmp);
    @(negedge clk);
    if (cmp) compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int nxt, first, maxi, stale;
    logic [8*WL-1:0] row0_exp;
    int sd[4];

    s_rst = 1'b1; s_en = 1'b1; s_valid = 1'b0; s_r_in = '0; s_y_in = '0;

    model_reset();
    drive(1, 1, 0);
    tick(0);
    drive(1, 0, 0);
    tick(1);
    chk("reset_inflight", inflight, 0);
    chk("reset_lv", lay_valid[NL-2:0], 0);

    // Single vector with recognisable words.
    rst = 0; en = 1; in_valid = 1;
    for (int i = 0; i < NR; i++) r_in[i*WL +: WL] = WL'(i + 1);
    for (int k = 0; k < NL; k++) y_in[k*WL +: WL] = WL'(100 + k);
    for (int i = 0; i < 8; i++) row0_exp[i*WL +: WL] = WL'(i + 1);
    #1;
    tick(1);
    for (int c = 1; c <= 27; c++) begin
      drive(0, 1, 0);
      if (c == 1) begin
        chk("sv_y6", y_out[6*WL +: WL], 106);
        chk("sv_lv6", lay_valid[6], 1);
        chk("sv_inf1", inflight, 1);
      end
      if (c == 25) begin
        chk("sv_y0", y_out[0 +: WL], 100);
        chk("sv_row0", r_out[0 +: 8*WL], row0_exp);
        chk("sv_lv0", lay_valid[0], 1);
      end
      if (c == 26) chk("sv_inf0", inflight, 0);
      tick(1);
    end

    // Streaming 30 back-to-back vectors.
    nxt = 0; first = -1; maxi = 0;
    for (int c = 0; c < 60; c++) begin
      drive(0, 1, c < 30);
      if (c < 30) y_in[0 +: WL] = WL'(c);
      if (lay_valid[0]) begin
        if (first < 0) first = c;
        chk("st_seq", y_out[0 +: WL], nxt);
        nxt++;
      end
      if (int'(inflight) > maxi) maxi = int'(inflight);
      tick(1);
    end
    chk("st_first", first, 25);
    chk("st_count", nxt, 30);
    chk("st_max_inf", maxi, 25);

    // Stall: en low for cycles 3..7.
    first = -1;
    for (int c = 0; c < 40; c++) begin
      drive(0, !(c >= 3 && c <= 7), c == 0);
      if (lay_valid[0] && first < 0) first = c;
      tick(1);
    end
    chk("stall_arrive", first, 30);

    // Reset mid-flight.
    stale = 0;
    for (int c = 0; c < 50; c++) begin
      drive(c == 12, 1, c < 10);
      if (c == 13) begin
        chk("rst_lv", lay_valid, 0);
        chk("rst_inf", inflight, 0);
        chk("rst_r", r_out & ~rmask(NL-1), 0);
        chk("rst_y", y_out[(NL-1)*WL-1:0], 0);
      end
      if (c > 13 && lay_valid[NL-2:0] != 0) stale++;
      tick(1);
    end
    chk("rst_stale", stale, 0);

`ifdef SKEW_ZERO_GATE_EN
    for (int c = 0; c <= D0 + 1; c++) begin
      drive(0, 1, 0);
      r_in = '1; y_in = '1;
      #1;
      if (c == 0) chk("gate_top", r_out[(NR-1)*WL +: WL], 0);
      if (c == D0 + 1) chk("gate_rows", r_out, 0);
      tick(1);
    end
`endif

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
      tick(1);
    end

    // Small configuration: D = {5,3,1,0}.
    sd = '{5, 3, 1, 0};
    @(posedge clk); #1;
    s_rst = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < S_NR; i++) s_r_in[i*S_WL +: S_WL] = S_WL'(i + 1);
    for (int k = 0; k < S_NL; k++) s_y_in[k*S_WL +: S_WL] = S_WL'(100 + k);
    #1;
    for (int c = 0; c < 8; c++) begin
      logic [S_NL-1:0] lv_exp;
      for (int k = 0; k < S_NL; k++) lv_exp[k] = (c == sd[k]);
      chk($sformatf("p_lv_c%0d", c), s_lay_valid, lv_exp);
      if (c == 1) chk("p_inf1", s_inflight, 1);
      if (c == 3) begin
        chk("p_row1", s_r_out[4*S_WL +: 3*S_WL], {8'd7, 8'd6, 8'd5});
        chk("p_y1", s_y_out[S_WL +: S_WL], 101);
      end
      if (c == 5) begin
        chk("p_row0", s_r_out[0 +: 4*S_WL], {8'd4, 8'd3, 8'd2, 8'd1});
        chk("p_y0", s_y_out[0 +: S_WL], 100);
      end
      if (c == 6) chk("p_inf0", s_inflight, 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      for (int i = 0; i < S_NR*S_WL; i++) s_r_in[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < S_NL*S_WL; i++) s_y_in[i] = 1'($urandom_range(0, 1));
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mimo_layer_skew_buffer.md
Name: mimo_layer_skew_buffer

Overview:
- Parametrised input-alignment block for the K-best MIMO detector pipeline.
- Takes one packed upper-triangular R matrix and one Y vector per accepted cycle.
- Delays each R row and its Y element so that each detector layer stage receives its row exactly when the surviving paths from the layer above arrive.
- Replaces hard-coded per-layer shift chains. Adds valid tracking, a global stall, an in-flight count and generic layer count / stage latency.

Parameters:
- WL, 15, word length of every R and Y element (bits).
- NLAYER, 8, real-valued layers (2x antennas); also the number of R rows.
- STAGE_LAT, 4, latency in cycles of one detector layer stage (path generator and each DetectorStage).
- NR, NLAYER*(NLAYER+1)/2, packed R word count (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  global advance; 0 freezes every register, including valid and count.
- in_valid  in  1  r_in/y_in hold a new vector this cycle (sampled only when en=1).
- r_in  in  NR*WL  packed R. Row k (k=0 bottom) has NLAYER-k words starting at word offset off(k)=sum_{j<k}(NLAYER-j). Word 0 is at the LSBs; row NLAYER-1 is the single top word.
- y_in  in  NLAYER*WL  element k at bits [(k+1)*WL-1 : k*WL].
- r_out  out  NR*WL  same packing as r_in; row k is delayed by D(k).
- y_out  out  NLAYER*WL  element k is delayed by D(k).
- lay_valid  out  NLAYER  bit k is in_valid delayed by D(k).
- inflight  out  clog2(NLAYER*STAGE_LAT+2)  vectors accepted whose layer-0 data has not yet left.

Behaviour:
- Delay per layer:
  - D(NLAYER-1)=0: top row, pure combinational pass-through to the path generator.
  - D(k)=1+STAGE_LAT*(NLAYER-2-k) for k<NLAYER-1.
  - Defaults give D(6)=1, D(5)=5, ..., D(0)=25.
- Each delayed layer is a shift chain of D(k) registers holding {row k R words, y[k], valid}. Row widths differ, so storage per layer is exactly (NLAYER-k+1)*WL+1 bits.
- en=1: all chains shift by one position. en=0: all chains hold. Pass-through layer NLAYER-1 follows its inputs regardless of en.
- Valid input: in_valid is ANDed with en at chain entry. Data words are loaded unconditionally when en=1; no data gating in the default build.
- rst=1 at a clk edge: every chain register (data and valid) and inflight go to 0, whatever en is. Outputs of delayed layers read 0 on the following cycle. The pass-through layer still mirrors its inputs.
- Reset mid-operation discards all in-flight vectors; no partial output appears afterwards.
- inflight counting:
  - +1 when en&in_valid.
  - -1 when en&lay_valid[0].
  - Both in the same cycle: unchanged.
  - Never wraps: at most D(0)=NLAYER*STAGE_LAT-2*STAGE_LAT+1 vectors can be in flight, and the counter width covers that.
- Back-to-back vectors every cycle are supported; throughput is 1 vector/cycle.
- NLAYER=2 is legal: only D(0)=1 exists.
- NLAYER<2 or STAGE_LAT<1 is a compile-time error (generate-time $error).

Optional Feature:
- Macro: SKEW_ZERO_GATE_EN.
- Defined: chain data registers load 0 when en&~in_valid. The pass-through layer's r_out/y_out are forced to 0 when in_valid=0. Invalid slots are therefore all-zero on r_out/y_out, which saves toggle power.
- Undefined: data loads raw inputs regardless of valid. Output data in invalid slots is don't-care.

Test Plan:
- Single vector, defaults: r_in word i = i+1, y_in[k]=100+k, in_valid for 1 cycle, en=1.
  - y_out[6]=106 and lay_valid[6]=1 exactly 1 cycle later.
  - y_out[0]=100 and row-0 words 1..8 exactly 25 cycles later.
  - lay_valid[k] is a single-cycle pulse at D(k).
  - inflight goes 0→1, then back to 0 on the cycle after layer 0 emits.
- Streaming: 30 consecutive vectors with y_in[0]=n (n=0..29).
  - y_out[0] sequence 0..29 contiguous starting at cycle 25, no gaps or duplicates.
  - inflight saturates at 25 and never exceeds it.
- Stall: vector at t=0, en=0 during cycles 3..7 (5 cycles).
  - Layer-0 output arrives at cycle 30.
  - All lay_valid and inflight values are frozen during the stall.
- Reset mid-flight: 10 vectors streamed, rst=1 at cycle 12 for 1 cycle.
  - lay_valid=0 and inflight=0 from cycle 13.
  - Delayed outputs are 0 and no stale vector ever appears later.
- Parametrisation: NLAYER=4, STAGE_LAT=2, WL=8.
  - NR=10, D(2)=1, D(1)=3, D(0)=5.
  - Row-1 words (offsets 4..6) emerge together with y_out[1] 3 cycles after input.
- SKEW_ZERO_GATE_EN defined: in_valid=0 with r_in all-ones.
  - r_out top word = 0 immediately.
  - Delayed rows read 0 at their respective D(k).
